// File: rtl/video_rx_capture.sv
// Video receive capture: samples a strobed RGB 4:4:4 stream, buffers pixels
// in a small FIFO and writes each frame to one of two frame buffers over a
// UFI-style write port with ready/valid handshake.
module video_rx_capture #(
  parameter int pBusAdrsBit    = 32,
  parameter int pUfiBusWidth   = 12,
  parameter int pHdisplayWidth = 11,
  parameter int pVdisplayWidth = 11,
  parameter int pFifoDepth     = 16
) (
  input  logic                      iSysClk,
  input  logic                      iSysRst,
  input  logic                      iPixEn,
  input  logic                      iVSync,
  input  logic                      iVde,
  input  logic [3:0]                iColorR,
  input  logic [3:0]                iColorG,
  input  logic [3:0]                iColorB,
  input  logic [pHdisplayWidth:0]   iHdisplay,
  input  logic [pVdisplayWidth:0]   iVdisplay,
  input  logic [pBusAdrsBit-1:0]    iCapAdrs1,
  input  logic [pBusAdrsBit-1:0]    iCapAdrs2,
  input  logic                      iCapEn,
  output logic [pUfiBusWidth-1:0]   oMUfiWd,
  output logic [pBusAdrsBit-1:0]    oMUfiAdrs,
  output logic                      oMUfiWEd,
  output logic                      oMUfiVd,
  output logic                      oMUfiCmd,
  input  logic                      iMUfiRdy,
  output logic                      oFe,
  output logic                      oBufSel,
  output logic                      oOvf,
  output logic                      oFrameErr
);

  localparam int AW = (pFifoDepth > 1) ? $clog2(pFifoDepth) : 1;
  localparam int OW = AW + 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Previously sampled sync/enable levels (edge detection across strobes)
  logic vs_prev_q;
  logic vde_prev_q;

  // Line / frame counters
  logic [pHdisplayWidth:0] hcnt_q, hcnt_d;
  logic [pVdisplayWidth:0] vcnt_q, vcnt_d;
  logic                    line_act_q, line_act_d;

  // Status
  logic ovf_q, err_q, bufsel_q, fe_q;

  // FIFO storage, pointers carry an extra wrap bit
  logic [pUfiBusWidth-1:0] mem_q [pFifoDepth];
  logic [AW:0]             wptr_q, rptr_q;
  logic [AW:0]             mem_cnt;
  logic [OW-1:0]           occ;

  // Output register (head of the write stream)
  logic                    out_vld_q;
  logic [pUfiBusWidth-1:0] out_wd_q;
  logic [pBusAdrsBit-1:0]  adrs_q;

  // Control strobes from the FSM
  logic frame_start;
  logic push_req, push, ovf_set, err_set;
  logic clear_flags, latch_base, frame_done;
  logic fifo_full, all_empty;
  logic load, accept;
  logic [pUfiBusWidth-1:0] pix_w;

  assign frame_start = iPixEn & iVSync & ~vs_prev_q;
  assign pix_w       = pUfiBusWidth'({iColorR, iColorG, iColorB});

  // Occupancy includes the output register so the total buffered pixel
  // count never exceeds pFifoDepth.
  assign mem_cnt   = wptr_q - rptr_q;
  assign occ       = OW'(mem_cnt) + OW'(out_vld_q);
  assign fifo_full = (occ >= OW'(pFifoDepth));
  assign all_empty = (mem_cnt == '0) && !out_vld_q;

  assign push    = push_req & ~fifo_full;
  assign ovf_set = push_req & fifo_full;
  assign accept  = out_vld_q & iMUfiRdy;
  assign load    = (mem_cnt != '0) & (~out_vld_q | iMUfiRdy);

  // Remember the last sampled VSync/Vde so edges are seen between strobes
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      vs_prev_q  <= 1'b1;  // a VSync already high at release is not a frame start
      vde_prev_q <= 1'b0;
    end else if (iPixEn) begin
      vs_prev_q  <= iVSync;
      vde_prev_q <= iVde;
    end
  end

  // FSM state register
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, capture decisions and counter updates
  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    line_act_d  = line_act_q;
    push_req    = 1'b0;
    err_set     = 1'b0;
    clear_flags = 1'b0;
    latch_base  = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (iCapEn) begin
          state_d     = WAIT_VS;
          clear_flags = 1'b1;
        end
      end
      WAIT_VS: begin
        if (!iCapEn) begin
          state_d = IDLE;
        end else if (frame_start) begin
          state_d    = CAPTURE;
          latch_base = 1'b1;
          hcnt_d     = '0;
          vcnt_d     = '0;
          line_act_d = 1'b0;
        end
      end
      CAPTURE: begin
        if (iPixEn) begin
          if (frame_start) begin
            // New frame arrived before this one completed: abandon it
            err_set = 1'b1;
            state_d = DRAIN;
          end else if (iVde) begin
            push_req   = 1'b1;
            hcnt_d     = hcnt_q + 1'b1;
            line_act_d = 1'b1;
          end else if (vde_prev_q && line_act_q) begin
            // End of a line: verify its length, then advance the line count
            if (hcnt_q != iHdisplay) begin
              err_set = 1'b1;
            end
            hcnt_d     = '0;
            vcnt_d     = vcnt_q + 1'b1;
            line_act_d = 1'b0;
            if (vcnt_d == iVdisplay) begin
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (all_empty) begin
          frame_done = 1'b1;
          state_d    = iCapEn ? WAIT_VS : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Horizontal / vertical counters
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      line_act_q <= 1'b0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      line_act_q <= line_act_d;
    end
  end

  // Sticky flags, buffer select and frame-end pulse
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      bufsel_q <= 1'b1;
      fe_q     <= 1'b0;
    end else begin
      if (clear_flags) begin
        ovf_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        if (ovf_set) ovf_q <= 1'b1;
        if (err_set) err_q <= 1'b1;
      end
      if (frame_done) bufsel_q <= ~bufsel_q;
      fe_q <= frame_done;
    end
  end

  // FIFO storage write (data only, no reset needed)
  always_ff @(posedge iSysClk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= pix_w;
    end
  end

  // FIFO pointers and output register handshake
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      out_vld_q <= 1'b0;
      out_wd_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (load) begin
        rptr_q    <= rptr_q + 1'b1;
        out_wd_q  <= mem_q[rptr_q[AW-1:0]];
        out_vld_q <= 1'b1;
      end else if (accept) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  // Write address: base of the other buffer at frame start, +1 per accepted word
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      adrs_q <= '0;
    end else if (latch_base) begin
      adrs_q <= bufsel_q ? iCapAdrs1 : iCapAdrs2;
    end else if (accept) begin
      adrs_q <= adrs_q + 1'b1;
    end
  end

  assign oMUfiWd   = out_wd_q;
  assign oMUfiAdrs = adrs_q;
  assign oMUfiWEd  = out_vld_q;
  assign oMUfiVd   = (state_q == CAPTURE) || (state_q == DRAIN);
  assign oMUfiCmd  = 1'b0;
  assign oFe       = fe_q;
  assign oBufSel   = bufsel_q;
  assign oOvf      = ovf_q;
  assign oFrameErr = err_q;

endmodule

// File: tb/tb_video_rx_capture.sv
// Directed bench for video_rx_capture: table of small frames plus hand
// sequences for overflow and a mid-frame reset.
module tb_video_rx_capture;

  localparam logic [31:0] A1 = 32'h0000_1000;
  localparam logic [31:0] A2 = 32'hFFFF_FFF8;  // second buffer wraps past 2^32

  logic        clk = 1'b0;
  logic        iSysRst, iPixEn, iVSync, iVde, iCapEn;
  logic [3:0]  iColorR, iColorG, iColorB;
  logic [11:0] iHdisplay, iVdisplay;
  logic [31:0] iCapAdrs1, iCapAdrs2;
  logic        iMUfiRdy = 1'b1;
  logic [11:0] oMUfiWd;
  logic [31:0] oMUfiAdrs;
  logic        oMUfiWEd, oMUfiVd, oMUfiCmd, oFe, oBufSel, oOvf, oFrameErr;

  video_rx_capture dut (
    .iSysClk(clk), .iSysRst(iSysRst), .iPixEn(iPixEn), .iVSync(iVSync), .iVde(iVde),
    .iColorR(iColorR), .iColorG(iColorG), .iColorB(iColorB),
    .iHdisplay(iHdisplay), .iVdisplay(iVdisplay),
    .iCapAdrs1(iCapAdrs1), .iCapAdrs2(iCapAdrs2), .iCapEn(iCapEn),
    .oMUfiWd(oMUfiWd), .oMUfiAdrs(oMUfiAdrs), .oMUfiWEd(oMUfiWEd), .oMUfiVd(oMUfiVd),
    .oMUfiCmd(oMUfiCmd), .iMUfiRdy(iMUfiRdy), .oFe(oFe), .oBufSel(oBufSel),
    .oOvf(oOvf), .oFrameErr(oFrameErr)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected-pixel model: main process appends, monitor consumes
  logic [11:0] exp_data [4096];
  int          wr_idx   = 0;
  int          rd_idx   = 0;
  logic [31:0] exp_base = 32'h0;
  int          frame_id = 0;
  int          seen_id  = 0;
  logic [31:0] exp_addr = 32'h0;
  int          n_writes = 0;
  int          fe_cnt   = 0;
  logic        prev_stall = 1'b0;
  logic [11:0] prev_wd  = 12'h0;
  logic [31:0] prev_adrs = 32'h0;

  // Write monitor: ordered data, consecutive addresses, hold-under-stall
  initial forever begin
    @(negedge clk);
    if (!iSysRst) begin
      prev_stall = 1'b0;
      rd_idx     = wr_idx;
    end else begin
      if (frame_id != seen_id) begin
        exp_addr = exp_base;
        seen_id  = frame_id;
      end
      if (oFe) fe_cnt++;
      if (prev_stall) begin
        check("hold_wed", oMUfiWEd, 1'b1);
        check("hold_wd", oMUfiWd, prev_wd);
        check("hold_adrs", oMUfiAdrs, prev_adrs);
      end
      if (oMUfiWEd && iMUfiRdy) begin
        n_writes++;
        if (rd_idx == wr_idx) begin
          total++;
          bad++;
          $display("FAIL spurious_write: got adrs 0x%0h data 0x%0h, expected no write", oMUfiAdrs, oMUfiWd);
        end else begin
          check("wr_data", oMUfiWd, exp_data[rd_idx & 4095]);
          check("wr_adrs", oMUfiAdrs, exp_addr);
          rd_idx++;
        end
        exp_addr = exp_addr + 32'd1;
      end
      prev_stall = oMUfiWEd && !iMUfiRdy;
      prev_wd    = oMUfiWd;
      prev_adrs  = oMUfiAdrs;
    end
  end

  // Ready pattern: 0 = always ready, 1 = toggling, 2 = held low
  int rdy_mode = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       iMUfiRdy = 1'b1;
      1:       iMUfiRdy = ~iMUfiRdy;
      default: iMUfiRdy = 1'b0;
    endcase
  end

  logic [11:0] pv = 12'h123;
  int          w_rst = 0;

  // One sampled video slot: strobe in the first of div cycles
  task automatic slot(input int div, input logic vs, input logic de, input logic [11:0] d);
    for (int i = 0; i < div; i++) begin
      @(posedge clk);
      #1;
      iPixEn = (i == 0);
      iVSync = vs;
      iVde   = de;
      {iColorR, iColorG, iColorB} = d;
    end
  endtask

  task automatic mid_reset();
    iSysRst = 1'b0;
    #1;
    check("mr_wed", oMUfiWEd, 1'b0);
    check("mr_vd", oMUfiVd, 1'b0);
    check("mr_cmd", oMUfiCmd, 1'b0);
    check("mr_wd", oMUfiWd, 12'h0);
    check("mr_adrs", oMUfiAdrs, 32'h0);
    check("mr_fe", oFe, 1'b0);
    check("mr_bufsel", oBufSel, 1'b1);
    check("mr_ovf", oOvf, 1'b0);
    check("mr_err", oFrameErr, 1'b0);
    w_rst = n_writes;
    repeat (3) @(posedge clk);
    #1;
    iSysRst = 1'b1;
  endtask

  task automatic drive_frame(input int h, input int v, input int div, input int short_line,
                             input int abort_line, input int rst_line, input int keep);
    int   kept;
    logic q_en;
    int   n;
    kept = 0;
    q_en = 1'b1;
    slot(div, 1'b0, 1'b0, 12'h0);
    slot(div, 1'b1, 1'b0, 12'h0);
    slot(div, 1'b0, 1'b0, 12'h0);
    check("vd_capture", oMUfiVd, 1'b1);
    for (int l = 0; l < v; l++) begin
      if (l == abort_line) begin
        slot(div, 1'b1, 1'b0, 12'h0);
        for (int p = 0; p < 3; p++) slot(div, 1'b0, 1'b1, 12'hABC);
        slot(div, 1'b0, 1'b0, 12'h0);
        break;
      end
      if (l == rst_line) begin
        mid_reset();
        q_en = 1'b0;
      end
      n = (l == short_line) ? h - 1 : h;
      for (int p = 0; p < n; p++) begin
        if (q_en && kept < keep) begin
          exp_data[wr_idx & 4095] = pv;
          wr_idx++;
          kept++;
        end
        slot(div, 1'b0, 1'b1, pv);
        pv = pv + 12'h0A7;
      end
      slot(div, 1'b0, 1'b0, 12'h0);
      slot(div, 1'b0, 1'b0, 12'h0);
    end
    @(posedge clk);
    #1;
    iPixEn = 1'b0;
    iVde   = 1'b0;
    iVSync = 1'b0;
  endtask

  task automatic wait_frame(input int f0, input int w0, input int exp_w);
    int k;
    k = 0;
    while (fe_cnt == f0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    check("fe_pulses", fe_cnt - f0, 1);
    check("writes", n_writes - w0, exp_w);
    check("model_drained", rd_idx, wr_idx);
  endtask

  typedef struct {
    int h; int v; int div; int rdy; int shortl; int abortl; int keep;
    bit restart; bit base2; int exp_w; bit ovf; bit err; bit sel;
  } vec_t;

  vec_t vecs[7];

  task automatic set_vec(input int i, input int h, input int v, input int div, input int rdy,
                         input int shortl, input int abortl, input int keep, input bit restart,
                         input bit base2, input int exp_w, input bit ovf, input bit err, input bit sel);
    vecs[i].h = h; vecs[i].v = v; vecs[i].div = div; vecs[i].rdy = rdy;
    vecs[i].shortl = shortl; vecs[i].abortl = abortl; vecs[i].keep = keep;
    vecs[i].restart = restart; vecs[i].base2 = base2; vecs[i].exp_w = exp_w;
    vecs[i].ovf = ovf; vecs[i].err = err; vecs[i].sel = sel;
  endtask

  initial begin
    int f0, w0;
    iSysRst = 1'b0; iPixEn = 1'b0; iVSync = 1'b0; iVde = 1'b0; iCapEn = 1'b0;
    iColorR = 4'h0; iColorG = 4'h0; iColorB = 4'h0;
    iHdisplay = 12'd0; iVdisplay = 12'd0;
    iCapAdrs1 = A1; iCapAdrs2 = A2;

    //          i  h   v  div rdy short abort keep  rst b2 writes ovf err sel
    set_vec(0,  8, 4, 3,  0,  -1,   -1,  9999, 1,  0, 32,    0,  0,  0);  // nominal
    set_vec(1,  6, 2, 3,  0,  -1,   -1,  9999, 0,  1, 12,    0,  0,  1);  // second buffer, wrap
    set_vec(2,  5, 3, 1,  0,  -1,   -1,  9999, 0,  0, 15,    0,  0,  0);  // third frame, full rate
    set_vec(3,  8, 3, 3,  1,  -1,   -1,  9999, 0,  1, 24,    0,  0,  1);  // backpressure
    set_vec(4,  6, 3, 3,  0,   1,   -1,  9999, 0,  0, 17,    0,  1,  0);  // short line
    set_vec(5,  6, 4, 3,  0,  -1,    2,  9999, 1,  1, 12,    0,  1,  1);  // VSync mid-frame
    set_vec(6, 40, 1, 1,  2,  -1,   -1,  16,   1,  0, 16,    1,  0,  0);  // overflow

    repeat (3) @(posedge clk);
    #1;
    check("rst_wed", oMUfiWEd, 1'b0);
    check("rst_vd", oMUfiVd, 1'b0);
    check("rst_cmd", oMUfiCmd, 1'b0);
    check("rst_adrs", oMUfiAdrs, 32'h0);
    check("rst_wd", oMUfiWd, 12'h0);
    check("rst_fe", oFe, 1'b0);
    check("rst_bufsel", oBufSel, 1'b1);
    check("rst_ovf", oOvf, 1'b0);
    check("rst_err", oFrameErr, 1'b0);
    iSysRst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      iHdisplay = 12'(vecs[i].h);
      iVdisplay = 12'(vecs[i].v);
      if (vecs[i].restart) begin
        iCapEn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        iCapEn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
      end
      exp_base = vecs[i].base2 ? A2 : A1;
      frame_id++;
      @(negedge clk);
      check("vd_wait", oMUfiVd, 1'b0);
      rdy_mode = vecs[i].rdy;
      f0 = fe_cnt;
      w0 = n_writes;
      drive_frame(vecs[i].h, vecs[i].v, vecs[i].div, vecs[i].shortl, vecs[i].abortl, -1, vecs[i].keep);
      rdy_mode = 0;
      wait_frame(f0, w0, vecs[i].exp_w);
      check("ovf", oOvf, vecs[i].ovf);
      check("frame_err", oFrameErr, vecs[i].err);
      check("bufsel", oBufSel, vecs[i].sel);
    end

    // Reset in the middle of a frame written to the second buffer
    iHdisplay = 12'd4;
    iVdisplay = 12'd6;
    exp_base = A2;
    frame_id++;
    f0 = fe_cnt;
    drive_frame(4, 6, 3, -1, -1, 2, 9999);
    repeat (10) @(negedge clk);
    check("no_write_after_rst", n_writes - w_rst, 0);
    check("no_fe_after_rst", fe_cnt - f0, 0);
    check("vd_after_rst", oMUfiVd, 1'b0);

    // Next frame after the reset goes to the first buffer
    iVdisplay = 12'd3;
    exp_base = A1;
    frame_id++;
    @(negedge clk);
    f0 = fe_cnt;
    w0 = n_writes;
    drive_frame(4, 3, 3, -1, -1, -1, 9999);
    wait_frame(f0, w0, 12);
    check("post_rst_bufsel", oBufSel, 1'b0);
    check("post_rst_ovf", oOvf, 1'b0);
    check("post_rst_err", oFrameErr, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_rx_capture.md
VIDEO_RX_CAPTURE -- requirements
Module: VideoRxCapture

Interface
REQ-001 The block SHALL have these parameters: pBusAdrsBit, default 32, UFI address width; pUfiBusWidth, default 12, UFI data width (4:4:4 pixel); pHdisplayWidth, default 11, horizontal counter width; pVdisplayWidth, default 11, vertical counter width; pFifoDepth, default 16, pixel FIFO entries (power of 2, at least 4).
REQ-002 The block SHALL have these ports, each given as name, direction, width, meaning:
- iSysClk  in  1  the single clock for all logic.
- iSysRst  in  1  asynchronous active-low reset.
- iPixEn  in  1  pixel strobe; video inputs are valid only in cycles where this is high.
- iVSync  in  1  vertical sync, active high.
- iVde  in  1  data enable, active high.
- iColorR  in  4  red component.
- iColorG  in  4  green component.
- iColorB  in  4  blue component.
- iHdisplay  in  pHdisplayWidth+1  pixels per line.
- iVdisplay  in  pVdisplayWidth+1  lines per frame.
- iCapAdrs1  in  pBusAdrsBit  frame buffer base address 1.
- iCapAdrs2  in  pBusAdrsBit  frame buffer base address 2.
- iCapEn  in  1  capture enable.
- oMUfiWd  out  pUfiBusWidth  write data, {R,G,B}.
- oMUfiAdrs  out  pBusAdrsBit  write address.
- oMUfiWEd  out  1  write data valid.
- oMUfiVd  out  1  transfer period active.
- oMUfiCmd  out  1  fixed 0 (Write).
- iMUfiRdy  in  1  bus ready.
- oFe  out  1  one-cycle frame-end pulse.
- oBufSel  out  1  buffer most recently completed (0 = Adrs1, 1 = Adrs2).
- oOvf  out  1  sticky FIFO overflow flag.
- oFrameErr  out  1  sticky pixel/line count mismatch flag.

Function
REQ-003 Video inputs SHALL be sampled only when iPixEn=1.
REQ-004 A VSync rising edge SHALL be a frame start; the edge is detected between successive sampled values.
REQ-005 The FSM SHALL have the states IDLE, WAIT_VS, CAPTURE and DRAIN.
REQ-006 From IDLE, the FSM SHALL go to WAIT_VS when iCapEn=1.
REQ-007 From WAIT_VS, the FSM SHALL go to CAPTURE on a frame start; the write base address is then latched to the buffer not equal to oBufSel.
REQ-008 In CAPTURE, each sampled pixel with iVde=1 SHALL be pushed to the FIFO as {iColorR,iColorG,iColorB}, and the horizontal counter SHALL increment.
REQ-009 On the falling edge of iVde (sampled): if the horizontal count is not equal to iHdisplay, the block SHALL set oFrameErr; then the horizontal count SHALL clear and the line count SHALL increment.
REQ-010 When the line count reaches iVdisplay, the FSM SHALL go to DRAIN.
REQ-011 A frame start while in CAPTURE SHALL set oFrameErr and SHALL go to DRAIN; that new frame SHALL NOT be captured.
REQ-012 From DRAIN, once the FIFO is empty and the last write has been accepted, the block SHALL pulse oFe for 1 cycle, toggle oBufSel, and return to WAIT_VS if iCapEn=1, otherwise to IDLE.
REQ-013 Deasserting iCapEn during CAPTURE SHALL take effect at frame end only.
REQ-014 oMUfiVd SHALL be 1 in CAPTURE and DRAIN, and 0 otherwise.
REQ-015 oMUfiWEd SHALL be 1 while the FIFO output register holds data; a word is accepted in any cycle where oMUfiWEd=1 and iMUfiRdy=1.
REQ-016 oMUfiWd and oMUfiAdrs SHALL remain stable while oMUfiWEd=1 and iMUfiRdy=0.
REQ-017 After each accepted word, oMUfiAdrs SHALL increment by 1, modulo 2^pBusAdrsBit.
REQ-018 The first word of a frame SHALL have oMUfiAdrs equal to the latched base address.
REQ-019 Latency from push to oMUfiWEd SHALL be at most 2 cycles when the FIFO is empty and iMUfiRdy=1.
REQ-020 Sustained throughput SHALL be 1 word per cycle.
REQ-021 A simultaneous push and pop SHALL leave the FIFO occupancy unchanged.
REQ-022 A push while the FIFO is full SHALL drop the pixel and set oOvf; the write address SHALL NOT advance for the dropped pixel.
REQ-023 oOvf and oFrameErr SHALL clear only on reset, or on the IDLE->WAIT_VS transition.

Reset
REQ-024 While iSysRst=0, the following SHALL hold asynchronously: FSM=IDLE, FIFO empty, oMUfiWEd=0, oMUfiVd=0, oMUfiCmd=0, oMUfiWd=0, oMUfiAdrs=0, oFe=0, oBufSel=1 (so the first frame is written to iCapAdrs1), oOvf=0, oFrameErr=0, and all counters=0.
REQ-025 A reset asserted mid-frame SHALL abandon the transfer immediately; after release, capture SHALL resume only from the next frame start.

Verification
REQ-026 Nominal: iHdisplay=480, iVdisplay=272, iPixEn every 3rd cycle, iMUfiRdy=1 -> 130560 writes at addresses iCapAdrs1..iCapAdrs1+130559, oFe=1 once, oBufSel=0, no flags set.
REQ-027 Double buffer: 2 consecutive frames -> the second frame is written starting at iCapAdrs2, oBufSel=1, and the third frame is written starting at iCapAdrs1 again.
REQ-028 Backpressure: iMUfiRdy toggling 1 cycle high, 1 cycle low, with iPixEn every 3rd cycle -> all pixels are written in order, oMUfiWd/oMUfiAdrs are held stable whenever iMUfiRdy=0, and oOvf=0.
REQ-029 Overflow: iPixEn=1 every cycle and iMUfiRdy=0 for 40 cycles, with pFifoDepth=16 -> oOvf=1, exactly 16 buffered pixels are later written at consecutive addresses, and the write address does not advance for dropped pixels.
REQ-030 Short line: one line with 479 pixels -> oFrameErr=1, and the frame still ends with an oFe pulse.
REQ-031 Mid-frame reset: assert iSysRst=0 at line 100 -> all outputs return to their reset values immediately, and after release the next write goes to iCapAdrs1 only after a VSync rising edge.
